// File: rtl/imm_ext_pipe_if.sv
// Request/result bundle for imm_ext_pipe.
//   master : drives in_valid/immed_in/mode, receives ext_immed_out/out_valid
//   slave  : the extension pipe itself
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic [IN_W-1:0]  immed_in;
  logic [1:0]       mode;
  logic [OUT_W-1:0] ext_immed_out;
  logic             out_valid;

  modport master (output in_valid, immed_in, mode,
                  input  ext_immed_out, out_valid);
  modport slave  (input  in_valid, immed_in, mode,
                  output ext_immed_out, out_valid);
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit (sign / zero / upper / branch).
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears every stage
//   stall : hold all stages, input request not captured
//   flush : clear every stage including the request presented this cycle
//   bus   : imm_ext_pipe_if.slave (in_valid, immed_in, mode -> ext_immed_out, out_valid)
// Latency is PIPE_DEPTH cycles, one result per cycle.
module imm_ext_pipe #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 32,
  parameter int PIPE_DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  imm_ext_pipe_if.slave bus
);

  generate
    if (IN_W < 2 || OUT_W < IN_W + 2 || PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_param
      $error("imm_ext_pipe: illegal IN_W/OUT_W/PIPE_DEPTH");
    end
  endgenerate

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;

  always_comb begin
    w_sext = {{(OUT_W-IN_W){bus.immed_in[IN_W-1]}}, bus.immed_in};
    w_ext  = w_sext;
    case (bus.mode)
      2'b00: w_ext = w_sext;
      2'b01: w_ext = {{(OUT_W-IN_W){1'b0}}, bus.immed_in};
      2'b10: w_ext = {bus.immed_in, {(OUT_W-IN_W){1'b0}}};
      2'b11: w_ext = {w_sext[OUT_W-3:0], 2'b00};  // top two sign bits drop out
      default: w_ext = w_sext;
    endcase
  end

  // Stage k lives at index k; index PIPE_DEPTH drives the outputs.
  logic [PIPE_DEPTH:1][OUT_W-1:0] r_data;
  logic [PIPE_DEPTH:1]            r_vld_pipe;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_data     <= '0;
      r_vld_pipe <= '0;
    end else if (!stall) begin
      r_vld_pipe[1] <= bus.in_valid;
      r_data[1]     <= bus.in_valid ? w_ext : '0;  // bubbles carry zero data
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_data[k]     <= r_data[k-1];
      end
    end
  end

  assign bus.out_valid     = r_vld_pipe[PIPE_DEPTH];
  assign bus.ext_immed_out = r_vld_pipe[PIPE_DEPTH] ? r_data[PIPE_DEPTH] : '0;

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the MIPS-lite datapath.
- Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper (LUI), branch offset.
- Carries the result through PIPE_DEPTH register stages with valid tracking, stall hold and flush, so it aligns with ID/EX pipeline timing.

Parameters:
IN_W, 16, immediate input width; legal range is 2 or more.
OUT_W, 32, extended output width; legal when OUT_W >= IN_W+2.
PIPE_DEPTH, 1, number of register stages (latency in cycles); legal range 1..4.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold all stages; no advance, no capture.
flush  input  1  kill all in-flight entries.
in_valid  input  1  immed_in/mode carry a valid request this cycle.
immed_in  input  IN_W  raw immediate.
mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
ext_immed_out  output  OUT_W  extended immediate from the last stage.
out_valid  output  1  ext_immed_out is valid.

Behaviour:
- Extension is computed combinationally from immed_in/mode and captured into stage 1.
  - 00 sign: {(OUT_W-IN_W){immed_in[IN_W-1]}, immed_in}.
  - 01 zero: {(OUT_W-IN_W){1'b0}, immed_in}.
  - 10 upper: immed_in in bits [OUT_W-1:OUT_W-IN_W], lower OUT_W-IN_W bits zero.
  - 11 branch: sign-extended value shifted left by 2; the top 2 sign bits are discarded and bits [1:0] are 0.
- Each stage k holds a data register (OUT_W bits) and a valid bit. Stage PIPE_DEPTH drives the outputs.
- Latency is exactly PIPE_DEPTH cycles: a request with in_valid=1 at edge N (with no stall) appears with out_valid=1 after edge N+PIPE_DEPTH-1, i.e. visible in the cycle following the PIPE_DEPTH-th capturing edge. Throughput is one result per cycle.
- ext_immed_out is forced to 0 whenever out_valid=0.
- Per-edge priority, highest first:
  - rst=1: all valid bits and data registers are cleared to 0. out_valid=0 and ext_immed_out=0 from the next cycle, regardless of stall, flush or in_valid.
  - flush=1: all valid bits and data registers are cleared to 0, including the request presented that cycle. Flush overrides stall.
  - stall=1: every stage holds data and valid, and the input request is ignored (not captured). The upstream stage is responsible for re-presenting it. Outputs remain stable across consecutive stall cycles.
  - Otherwise: stage1 <= {in_valid, ext(immed_in,mode)} and stage k <= stage k-1. An in_valid=0 cycle inserts a bubble (valid=0, data=0).
- Reset mid-operation discards all in-flight entries; no partial results are emitted afterwards.
- Flush in the same cycle as in_valid=1 means that request is lost. A request presented on the cycle after flush deasserts is captured normally.
- Bubbles preserve ordering. No reordering and no merging ever occur.
- The mode value is captured with its data, so changing mode while entries are in flight does not alter earlier results.
- No internal state beyond the stage registers. Illegal parameter values are rejected at elaboration.

Test Plan:
- (IN_W=16, OUT_W=32, PIPE_DEPTH=2) Mode 00: immed_in=0x8004 then 0x7FFF, back-to-back -> out_valid=1 for two consecutive cycles starting 2 cycles later, with outputs 0xFFFF8004 and then 0x00007FFF.
- Mode 01 with 0x8004 -> 0x00008004. Mode 10 with 0x1234 -> 0x12340000. Mode 11 with 0xFFFF -> 0xFFFFFFFC, and with 0x0003 -> 0x0000000C. All at 2-cycle latency.
- Stall:
  - Stimulus: issue A=0x0001 (mode 00) and B=0x0002 (mode 01), then hold stall=1 for 3 cycles while presenting C=0x0003.
  - Required: outputs freeze for the stall duration; A and B then emerge in order; C is not captured during the stall.
- Flush:
  - Stimulus: 2 valid entries in flight; assert flush together with stall and with in_valid=1 (0x00FF).
  - Required: next cycle out_valid=0 and ext_immed_out=0. No stale entries appear afterwards, and 0x00FF is never emitted.
- Reset: assert rst for 1 cycle with the pipeline full -> out_valid=0 and ext_immed_out=0 the next cycle. The first request after rst deasserts emerges with exact PIPE_DEPTH latency.
- Parameter sweep PIPE_DEPTH=1 and 4 (IN_W=8, OUT_W=16):
  - Latency equals PIPE_DEPTH.
  - Mode 00 with 0x80 -> 0xFF80.
  - Mode 10 with 0xAB -> 0xAB00.
  - Mode 11 with 0x81 -> 0xFE04.
